// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: tracks recent writers to pick EX operand forwarding
// slots and stalls ID on a load-use dependency that is still too young.
module forwarding_hazard_unit #(
    parameter int AW = 5,
    parameter int NSRC = 2,
    parameter int DEPTH = 3,
    parameter int LOAD_LAT = 1,
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_en,
    input  logic [AW-1:0]        id_dst,
    input  logic                 id_wr,
    input  logic                 id_is_load,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*FW-1:0]   fwd_sel,
    output logic [15:0]          stall_cnt
);
    logic [DEPTH:0] hValid, hWr;
    logic [LOAD_LAT-1:0] hLoad;
    logic [AW-1:0] hDst [DEPTH+1];
    logic [NSRC*AW-1:0] exSrc;
    logic [NSRC-1:0] exSrcEn, useLoad;
    logic issue;

    function automatic logic writes(logic v, logic w, logic [AW-1:0] d, logic [AW-1:0] r);
        return v && w && d != '0 && d == r;
    endfunction

    assign issue = id_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hValid <= '0;
            hWr <= '0;
            hLoad <= '0;
            for (int k = 0; k <= DEPTH; k++) hDst[k] <= '0;
            exSrc <= '0;
            exSrcEn <= '0;
            stall_cnt <= '0;
        end else begin
            hValid <= {hValid[DEPTH-1:0], issue};
            hWr <= {hWr[DEPTH-1:0], id_wr};
            // load flags only matter while the load is younger than LOAD_LAT
            hLoad <= LOAD_LAT'({hLoad, id_is_load});
            for (int k = DEPTH; k >= 1; k--) hDst[k] <= hDst[k-1];
            hDst[0] <= id_dst;
            exSrc <= id_src;
            exSrcEn <= issue ? id_src_en : '0;
            if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_comb begin
        fwd_sel = '0;
        for (int s = 0; s < NSRC; s++)
            for (int k = DEPTH; k >= 1; k--)
                if (exSrcEn[s] && writes(hValid[k], hWr[k], hDst[k], exSrc[s*AW +: AW]))
                    fwd_sel[s*FW +: FW] = FW'(k);
    end

    // scan oldest to youngest so the youngest matching writer decides
    always_comb begin
        useLoad = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = DEPTH - 1; k >= LOAD_LAT; k--)
                if (id_src_en[s] && writes(hValid[k], hWr[k], hDst[k], id_src[s*AW +: AW]))
                    useLoad[s] = 1'b0;
            for (int k = LOAD_LAT - 1; k >= 0; k--)
                if (id_src_en[s] && writes(hValid[k], hWr[k], hDst[k], id_src[s*AW +: AW]))
                    useLoad[s] = hLoad[k];
        end
    end

    assign stall = id_valid && !flush && |useLoad;
endmodule
